// File: rtl/systolic_array_pkg.sv
// Shared definitions for the weight-stationary systolic array.
//   ctrl_state_t  : sequencer state encoding
//   SIZE_DEFAULT  : default array dimension N (N x N PEs)
//   pipe_depth()  : advances from an activation row entering to its result
//                   row leaving (2N-1). The PE-grid wrapper uses it for skew.
package systolic_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_COMMIT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  localparam int SIZE_DEFAULT = 4;

  function automatic int pipe_depth(input int size);
    return 2 * size - 1;
  endfunction

endpackage

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the FP32 x int8 weight-stationary systolic array.
// A job loads SIZE weight rows, commits them, then streams M activation rows.
// The skewed pipeline is drained with zero bubbles until the last result row
// has left. The block is the only source of array enables.
//
// Ports
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   start_i, num_rows_i           : job request and activation row count M
//   busy_o, done_o                : job in flight / one-cycle end pulse
//   weight_valid_i/weight_ready_o : weight-row handshake
//   act_valid_i/act_ready_o       : activation-row handshake
//   res_valid_o/res_ready_i       : result-row handshake
//   array_weight_shift_o          : shift one weight row into the array
//   array_weight_commit_o         : copy shifted weights to active registers
//   array_advance_o               : step the array pipeline
//   array_bubble_o                : feed zero activations on this advance
module systolic_array_ctrl
  import systolic_array_pkg::*;
#(
  parameter int SIZE      = SIZE_DEFAULT,
  parameter int ROW_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ROW_CNT_W-1:0] num_rows_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 weight_valid_i,
  output logic                 weight_ready_o,
  input  logic                 act_valid_i,
  output logic                 act_ready_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 array_weight_shift_o,
  output logic                 array_weight_commit_o,
  output logic                 array_advance_o,
  output logic                 array_bubble_o
);

  localparam int KW   = ROW_CNT_W + 1;
  localparam int WC_W = $clog2(SIZE + 1);
  localparam logic [KW-1:0]   L_K       = KW'(pipe_depth(SIZE));
  localparam logic [WC_W-1:0] WC_LAST   = WC_W'(SIZE - 1);

  ctrl_state_t          state, state_nxt;
  logic [WC_W-1:0]      wcnt;
  logic [KW-1:0]        k;
  logic [ROW_CNT_W-1:0] m;

  // k is one wider than M, so M + L never wraps.
  logic [KW-1:0] m_k;
  logic          k_ge_l;
  logic          last_act;
  logic          last_drain;

  assign m_k        = {1'b0, m};
  assign k_ge_l     = (k >= L_K);
  // k counts only accepted activations while streaming, so it doubles as the
  // accepted-activation count: the M-th accept is the one taking k to M.
  assign last_act   = ((k + KW'(1)) == m_k);
  assign last_drain = ((k + KW'(1)) == (m_k + L_K));

  always_comb begin
    state_nxt             = state;
    busy_o                = (state != ST_IDLE);
    done_o                = 1'b0;
    weight_ready_o        = 1'b0;
    act_ready_o           = 1'b0;
    res_valid_o           = 1'b0;
    array_weight_shift_o  = 1'b0;
    array_weight_commit_o = 1'b0;
    array_advance_o       = 1'b0;
    array_bubble_o        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start_i) state_nxt = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        weight_ready_o       = 1'b1;
        array_weight_shift_o = weight_valid_i;
        if (weight_valid_i && (wcnt == WC_LAST)) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        array_weight_commit_o = 1'b1;
        state_nxt = (m != '0) ? ST_STREAM : ST_DONE;
      end
      ST_STREAM: begin
        // Until the first result reaches the edge there is nothing to stall on.
        act_ready_o     = !k_ge_l || res_ready_i;
        array_advance_o = act_valid_i && act_ready_o;
        res_valid_o     = act_valid_i && k_ge_l;
        if (array_advance_o && last_act) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        array_bubble_o  = 1'b1;
        res_valid_o     = k_ge_l;
        array_advance_o = !k_ge_l || res_ready_i;
        if (array_advance_o && last_drain) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      wcnt  <= '0;
      k     <= '0;
      m     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start_i) begin
        m    <= num_rows_i;
        wcnt <= '0;
        k    <= '0;
      end
      if (array_weight_shift_o) wcnt <= wcnt + WC_W'(1);
      // k restarts at commit; advances only happen after it.
      if (array_weight_commit_o) k <= '0;
      else if (array_advance_o)  k <= k + KW'(1);
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
module tb_systolic_array_ctrl;
  localparam int SIZE = 4;
  localparam int RW   = 16;
  localparam int L    = 2 * SIZE - 1;

  // reference phases, named after the job's life cycle
  localparam int P_IDLE = 0, P_LOAD = 1, P_COMMIT = 2, P_STREAM = 3, P_DRAIN = 4, P_DONE = 5;

  logic clk = 0;
  logic rst_i, start_i, weight_valid_i, act_valid_i, res_ready_i;
  logic [RW-1:0] num_rows_i;
  logic busy_o, done_o, weight_ready_o, act_ready_o, res_valid_o;
  logic array_weight_shift_o, array_weight_commit_o, array_advance_o, array_bubble_o;

  systolic_array_ctrl #(.SIZE(SIZE), .ROW_CNT_W(RW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_rows_i(num_rows_i),
    .busy_o(busy_o), .done_o(done_o),
    .weight_valid_i(weight_valid_i), .weight_ready_o(weight_ready_o),
    .act_valid_i(act_valid_i), .act_ready_o(act_ready_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .array_weight_shift_o(array_weight_shift_o),
    .array_weight_commit_o(array_weight_commit_o),
    .array_advance_o(array_advance_o), .array_bubble_o(array_bubble_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference model state: job progress as plain integers
  int ph = P_IDLE, wrows = 0, kk = 0, mm = 0;
  int tot_shift = 0, tot_adv = 0, tot_xfer = 0, n_done = 0;

  // trace of observed outputs, indexed by cycle since the job's start cycle
  // bit: 8 busy 7 done 6 wready 5 aready 4 rvalid 3 shift 2 commit 1 adv 0 bubble
  logic [8:0] tr [64];
  int t = 0;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] col(input int b);
    logic [63:0] r = '0;
    for (int i = 0; i < 64; i++) r[i] = tr[i][b];
    return r;
  endfunction

  task automatic clear_trace();
    for (int i = 0; i < 64; i++) tr[i] = '0;
    t = 0;
  endtask

  function automatic logic [8:0] model_out(input logic wv, input logic av, input logic rr);
    logic busy, done, wrdy, ardy, rv, sh, cm, adv, bub;
    busy = (ph != P_IDLE);
    done = (ph == P_DONE);
    wrdy = (ph == P_LOAD);
    sh   = (ph == P_LOAD) && wv;
    cm   = (ph == P_COMMIT);
    ardy = (ph == P_STREAM) && (kk < L || rr);
    bub  = (ph == P_DRAIN);
    adv  = (ph == P_STREAM) ? (av && ardy) : (ph == P_DRAIN) ? (kk < L || rr) : 1'b0;
    rv   = (ph == P_STREAM) ? (av && kk >= L) : (ph == P_DRAIN) ? (kk >= L) : 1'b0;
    return {busy, done, wrdy, ardy, rv, sh, cm, adv, bub};
  endfunction

  task automatic model_step(input logic st, input int nr, input logic wv, input logic adv,
                            input logic rs);
    if (rs) begin
      ph = P_IDLE; kk = 0; wrows = 0;
      return;
    end
    case (ph)
      P_IDLE: if (st) begin
        mm = nr; kk = 0; wrows = 0; ph = P_LOAD;
        tot_shift = 0; tot_adv = 0; tot_xfer = 0;
      end
      P_LOAD: if (wv) begin
        wrows++;
        if (wrows == SIZE) ph = P_COMMIT;
      end
      P_COMMIT: begin kk = 0; ph = (mm > 0) ? P_STREAM : P_DONE; end
      P_STREAM: if (adv) begin
        kk++;
        if (kk == mm) ph = P_DRAIN;
      end
      P_DRAIN: if (adv) begin
        kk++;
        if (kk == mm + L) ph = P_DONE;
      end
      default: ph = P_IDLE;
    endcase
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic cyc(input logic st, input int nr, input logic wv, input logic av,
                     input logic rr, input logic rs);
    logic [8:0] obs, exp;
    start_i = st; num_rows_i = RW'(nr); weight_valid_i = wv;
    act_valid_i = av; res_ready_i = rr; rst_i = rs;
    @(negedge clk);
    exp = model_out(wv, av, rr);
    obs = {busy_o, done_o, weight_ready_o, act_ready_o, res_valid_o,
           array_weight_shift_o, array_weight_commit_o, array_advance_o, array_bubble_o};
    if (!rs) chk("outs", obs, exp);
    if (t < 64) tr[t] = obs;
    if (!rs) begin
      tot_shift += int'(array_weight_shift_o);
      tot_adv   += int'(array_advance_o);
      tot_xfer  += int'(res_valid_o && rr);
      n_done    += int'(done_o);
      if (ph == P_DONE) begin
        chk("job_shifts", tot_shift, SIZE);
        chk("job_advances", tot_adv, (mm > 0) ? mm + L : 0);
        chk("job_xfers", tot_xfer, mm);
      end
    end
    @(posedge clk);
    model_step(st, nr, wv, exp[1], rs);
    #1;
    t++;
  endtask

  task automatic do_reset();
    cyc(1'b1, 5, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    int nj;
    // ---- reset state: outputs all zero with every input high
    do_reset();
    do_reset();
    clear_trace();
    cyc(1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_outs", tr[0], 0);

    // ---- M=3, all handshakes high
    do_reset(); clear_trace();
    cyc(1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (19) cyc(1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("m3_shift",  col(3), 64'h1E);
    chk("m3_commit", col(2), 64'h20);
    chk("m3_adv",    col(1), 64'hFFC0);
    chk("m3_bubble", col(0), 64'hFE00);
    chk("m3_rvalid", col(4), 64'hE000);
    chk("m3_done",   col(7), 64'h10000);
    chk("m3_busy",   col(8), 64'h1FFFE);

    // ---- M=0: commit then done, no advances
    do_reset(); clear_trace();
    cyc(1'b1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (9) cyc(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("m0_shift",  col(3), 64'h1E);
    chk("m0_commit", col(2), 64'h20);
    chk("m0_done",   col(7), 64'h40);
    chk("m0_adv",    col(1), 64'h0);
    chk("m0_rvalid", col(4), 64'h0);

    // ---- weight stall: valid toggles 1,0,1,0...
    do_reset(); clear_trace();
    cyc(1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 24; i++) cyc(1'b0, 1, (i % 2) == 1, 1'b1, 1'b1, 1'b0);
    chk("wstall_shift",  col(3), 64'hAA);
    chk("wstall_commit", col(2), 64'h100);

    // ---- backpressure: M=5, res_ready low at t14..t16 (k=8)
    do_reset(); clear_trace();
    cyc(1'b1, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 26; i++) cyc(1'b0, 5, 1'b1, 1'b1, !(i >= 14 && i <= 16), 1'b0);
    chk("bp_adv",    col(1), 64'h1E3FC0);
    chk("bp_rvalid", col(4), 64'h1FE000);
    chk("bp_done",   col(7), 64'h200000);
    chk("bp_xfers",  tot_xfer, 5);
    chk("bp_kfinal", tot_adv, 12);

    // ---- reset in the 2nd STREAM cycle, then restart with M=2
    do_reset(); clear_trace();
    n_done = 0;
    cyc(1'b1, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("abort_outs", tr[8], 0);
    chk("abort_nodone", n_done, 0);
    clear_trace();
    cyc(1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (19) cyc(1'b0, 2, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("restart_done", col(7), 64'h8000);
    chk("restart_adv",  col(1), 64'h7FC0);

    // ---- start held high: back-to-back jobs, M=1
    do_reset(); clear_trace();
    repeat (31) cyc(1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("held_done", col(7), (64'h1 << 14) | (64'h1 << 29));
    chk("held_busy", col(8) & 64'h7FFF_FFFF, 64'h7FFE | (64'h3FFF << 16));

    // ---- randomized jobs against the reference model
    do_reset();
    n_done = 0;
    for (int j = 0; j < 12; j++) begin
      clear_trace();
      cyc(1'b1, $urandom_range(12), 1'b1, 1'b1, 1'b1, 1'b0);
      nj = 0;
      while (ph != P_IDLE && nj < 400) begin
        cyc(1'($urandom_range(1)), $urandom_range(20),
            $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0, 1'b0);
        nj++;
      end
      chk("rand_job_end", nj < 400, 1);
    end
    chk("rand_dones", n_done, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
